param_memo: RTL and testbench
=============================

PARAM_MEMO -- requirements
Module: param_memo

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 32, giving the word width in bits; it must be a multiple of 8.
REQ-002 The block SHALL expose parameter ADDR_W, default 5, giving the address width; DEPTH = 2**ADDR_W words.
REQ-003 The block SHALL expose port clk, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-004 The block SHALL expose port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL expose port wr_enable, input, 1 bit: write request.
REQ-006 The block SHALL expose port write_addr, input, ADDR_W bits: write address.
REQ-007 The block SHALL expose port write_data, input, DATA_W bits: write data.
REQ-008 The block SHALL expose port wr_be, input, DATA_W/8 bits: per-byte write enable; bit i covers data bits [8i+7:8i].
REQ-009 The block SHALL expose port rd_enable, input, 1 bit: read request.
REQ-010 The block SHALL expose port read_addr, input, ADDR_W bits: read address.
REQ-011 The block SHALL expose port clear_req, input, 1 bit: single-cycle request to zero the whole array.
REQ-012 The block SHALL expose port read_out, output, DATA_W bits: registered read data.
REQ-013 The block SHALL expose port rd_valid, output, 1 bit: read_out holds the result of a read accepted on the previous cycle.
REQ-014 The block SHALL expose port busy, output, 1 bit: the clear sequence is in progress and requests are ignored.

Function
REQ-015 FSM states: IDLE and CLEAR, plus a clear counter clr_addr, ADDR_W bits.
REQ-016 In CLEAR, each cycle writes 0 to mem[clr_addr] and increments clr_addr; after clr_addr = DEPTH-1 the FSM goes to IDLE with busy = 0 on the next cycle; a clear takes exactly DEPTH cycles.
REQ-017 In IDLE, clear_req = 1 moves the FSM to CLEAR with clr_addr = 0; clear_req during CLEAR is ignored and does not restart the sequence.
REQ-018 busy SHALL be 1 exactly while the state is CLEAR.
REQ-019 In IDLE with wr_enable = 1, each byte i with wr_be[i] = 1 is written to mem[write_addr] at the clock edge; bytes with wr_be[i] = 0 keep their value.
REQ-020 In IDLE with rd_enable = 1, read_out updates at the next edge (latency 1) and rd_valid = 1 for that one cycle; otherwise rd_valid = 0 and read_out holds its value.
REQ-021 Read-during-write to the same address is write-first: enabled bytes come from write_data and the remaining bytes from the stored word.
REQ-022 In CLEAR, wr_enable and rd_enable are ignored (no array change, rd_valid = 0).
REQ-023 If clear_req and wr_enable are asserted in the same IDLE cycle, the write is performed and the clear starts next cycle, so the written word is then cleared.
REQ-024 Addresses are always in range; no out-of-range handling is required.

Reset
REQ-025 rst = 1 SHALL immediately force state = CLEAR, clr_addr = 0, read_out = 0, rd_valid = 0, busy = 1.
REQ-026 The array itself SHALL NOT be reset; after rst deasserts the clear sequence zeroes it in DEPTH cycles.
REQ-027 rst asserted mid-clear SHALL restart the clear from address 0.

Structure
REQ-028 Package param_memo_pkg SHALL hold the state enumeration (IDLE, CLEAR) and the default DATA_W/ADDR_W constants.
REQ-029 The FSM and clr_addr counter SHALL be one sub-module, memo_clear_ctrl; the array, byte-merge and read register stay in param_memo.

Verification (DATA_W=32, ADDR_W=5)
REQ-030 Release rst -> busy = 1 for 32 cycles then 0; read addr 7 -> read_out = 0, rd_valid = 1 one cycle later.
REQ-031 Write addr 10 data 20, wr_be = 4'b1111; next cycle read addr 10 -> read_out = 20 one cycle later.
REQ-032 Write addr 11 0xAABBCCDD with be 1111, then 0x11223344 with be 0101 -> read addr 11 = 0xAA22CC44.
REQ-033 Same-cycle write addr 10 data 0x55 (be 1111) and read addr 10 -> read_out = 0x00000055 next cycle.
REQ-034 clear_req after data -> busy for 32 cycles, a write to addr 3 during busy is dropped, then read addr 10 and addr 3 = 0.
REQ-035 Assert rst when clr_addr = 15 -> busy stays 1 for a full 32 cycles after release.

Source files
------------

// File: rtl/param_memo_pkg.sv
// Shared types and default sizing for the param_memo block.
package param_memo_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/memo_clear_ctrl.sv
// Clear sequencer: walks clr_addr through every word while busy.
module memo_clear_ctrl
    import param_memo_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_req,
    output logic              busy,
    output logic              clr_we_c,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] clr_addr_nx;

    // busy is registered from the next state so it always equals (state == CLEAR)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= CLEAR;
            clr_addr <= '0;
            busy     <= 1'b1;
        end else begin
            state    <= state_nx;
            clr_addr <= clr_addr_nx;
            busy     <= (state_nx == CLEAR);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (clear_req) state_nx = CLEAR;
            CLEAR:   if (clr_addr == LAST_ADDR) state_nx = IDLE;
            default: state_nx = CLEAR;
        endcase
    end

    always_comb begin
        clr_we_c    = 1'b0;
        clr_addr_nx = clr_addr;
        case (state)
            IDLE:    clr_addr_nx = '0;
            CLEAR: begin
                clr_we_c    = 1'b1;
                clr_addr_nx = clr_addr + ADDR_W'(1);
            end
            default: clr_addr_nx = '0;
        endcase
    end

endmodule

// File: rtl/param_memo.sv
// Byte-writable memory with registered write-first read and a sequenced clear.
module param_memo
    import param_memo_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_enable,
    input  logic [ADDR_W-1:0]   write_addr,
    input  logic [DATA_W-1:0]   write_data,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic                rd_enable,
    input  logic [ADDR_W-1:0]   read_addr,
    input  logic                clear_req,
    output logic [DATA_W-1:0]   read_out,
    output logic                rd_valid,
    output logic                busy
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              clr_we_c;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] rd_word_c;
    logic              rd_take_c;

    memo_clear_ctrl #(.ADDR_W(ADDR_W)) u_clear_ctrl (
        .clk       (clk),
        .rst       (rst),
        .clear_req (clear_req),
        .busy      (busy),
        .clr_we_c  (clr_we_c),
        .clr_addr  (clr_addr)
    );

    // Array is deliberately not reset; the clear sequence zeroes it instead
    always_ff @(posedge clk) begin
        if (clr_we_c) begin
            mem[clr_addr] <= '0;
        end else if (wr_enable) begin
            for (int i = 0; i < int'(NB); i++) begin
                if (wr_be[i]) mem[write_addr][8*i +: 8] <= write_data[8*i +: 8];
            end
        end
    end

    // Write-first bypass for a same-address read
    always_comb begin
        rd_word_c = mem[read_addr];
        for (int i = 0; i < int'(NB); i++) begin
            if (wr_enable && wr_be[i] && (write_addr == read_addr))
                rd_word_c[8*i +: 8] = write_data[8*i +: 8];
        end
    end

    assign rd_take_c = rd_enable && !busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_out <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_take_c;
            if (rd_take_c) read_out <= rd_word_c;
        end
    end

endmodule

// File: tb/tb_param_memo.sv
// Directed self-checking bench for param_memo at DATA_W=32, ADDR_W=5.
module tb_param_memo;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_enable;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [3:0]  wr_be;
    logic        rd_enable;
    logic [4:0]  read_addr;
    logic        clear_req;
    logic [31:0] read_out;
    logic        rd_valid;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int n;

    param_memo #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_enable  (wr_enable),
        .write_addr (write_addr),
        .write_data (write_data),
        .wr_be      (wr_be),
        .rd_enable  (rd_enable),
        .read_addr  (read_addr),
        .clear_req  (clear_req),
        .read_out   (read_out),
        .rd_valid   (rd_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_enable = 1'b0; write_addr = '0; write_data = '0; wr_be = '0;
        rd_enable = 1'b0; read_addr = '0; clear_req = 1'b0;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_enable = 1'b1; write_addr = a; write_data = d; wr_be = be;
        step();
        wr_enable = 1'b0; wr_be = '0;
    endtask

    task automatic do_read(input logic [4:0] a, input logic [31:0] exp, input string tag);
        rd_enable = 1'b1; read_addr = a;
        step();
        rd_enable = 1'b0;
        check({tag, "_data"}, read_out, exp);
        check({tag, "_valid"}, 32'(rd_valid), 32'd1);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_rdata", read_out, 32'd0);

        // Initial clear after reset release
        rst = 1'b0;
        n = 0;
        while (busy && n < 100) begin step(); n++; end
        check("init_clear_len", 32'(n), 32'd32);

        do_read(5'd7, 32'd0, "rd7");
        step();
        check("rd_valid_drop", 32'(rd_valid), 32'd0);

        do_write(5'd10, 32'd20, 4'b1111);
        do_read(5'd10, 32'd20, "rd10");

        do_write(5'd11, 32'hAABBCCDD, 4'b1111);
        do_write(5'd11, 32'h11223344, 4'b0101);
        do_read(5'd11, 32'hAA22CC44, "rd11_be");

        // Same-cycle write and read, full and partial byte enables
        wr_enable = 1'b1; write_addr = 5'd10; write_data = 32'h55; wr_be = 4'b1111;
        rd_enable = 1'b1; read_addr = 5'd10;
        step();
        idle_inputs();
        check("wf_full", read_out, 32'h00000055);
        wr_enable = 1'b1; write_addr = 5'd11; write_data = 32'h99887766; wr_be = 4'b1000;
        rd_enable = 1'b1; read_addr = 5'd11;
        step();
        idle_inputs();
        check("wf_part", read_out, 32'h9922CC44);
        step();
        check("rd_hold", read_out, 32'h9922CC44);

        // Clear with a same-cycle write; mid-clear requests ignored
        do_write(5'd3, 32'h0BADF00D, 4'b1111);
        wr_enable = 1'b1; write_addr = 5'd5; write_data = 32'h1234; wr_be = 4'b1111;
        clear_req = 1'b1;
        step();
        idle_inputs();
        check("clr_busy0", 32'(busy), 32'd1);
        n = 0;
        while (busy && n < 100) begin
            idle_inputs();
            if (n == 10) clear_req = 1'b1;
            if (n == 31) begin
                wr_enable = 1'b1; write_addr = 5'd3; write_data = 32'hFFFFFFFF; wr_be = 4'b1111;
                rd_enable = 1'b1; read_addr = 5'd3;
            end
            step();
            if (n == 0) check("clr_no_valid", 32'(rd_valid), 32'd0);
            n++;
        end
        idle_inputs();
        check("clr_len", 32'(n), 32'd32);
        check("clr_last_valid", 32'(rd_valid), 32'd0);
        do_read(5'd10, 32'd0, "clr_rd10");
        do_read(5'd3, 32'd0, "clr_rd3");
        do_read(5'd5, 32'd0, "clr_rd5");

        // Reset in the middle of a clear restarts it
        do_write(5'd20, 32'hDEADBEEF, 4'b1111);
        rd_enable = 1'b1; read_addr = 5'd20; clear_req = 1'b1;
        step();
        idle_inputs();
        check("rdclr_data", read_out, 32'hDEADBEEF);
        check("rdclr_valid", 32'(rd_valid), 32'd1);
        for (int i = 0; i < 15; i++) step();
        check("mid_hold", read_out, 32'hDEADBEEF);
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rdata", read_out, 32'd0);
        check("async_busy", 32'(busy), 32'd1);
        step();
        rst = 1'b0;
        n = 0;
        while (busy && n < 100) begin step(); n++; end
        check("restart_len", 32'(n), 32'd32);
        do_read(5'd20, 32'd0, "rst_rd20");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
